// File: rtl/ioblock_pkg.sv
// Shared IO-block definitions: frame state enum, TSMUX drive-policy encodings,
// frame bit levels and the TSMUX output-enable decode used by tx and rx blocks.
// Optional build macro IOBLOCK_TX_PARITY_EN adds the ST_PARITY state.
package ioblock_pkg;

`ifdef IOBLOCK_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

  // TSMUX drive policy; any code with bit 1 set means always drive.
  localparam logic [1:0] TS_NEVER  = 2'b00;
  localparam logic [1:0] TS_FRAME  = 2'b01;
  localparam logic [1:0] TS_ALWAYS = 2'b1?;

  // Pad levels for the frame delimiters.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Output-enable decode: 'framing' is whether the block will be mid-frame
  // after the coming edge.
  function automatic logic ts_oe(input logic [1:0] tsmux, input logic framing);
    logic oe;
    oe = 1'b0;
    casez (tsmux)
      TS_NEVER:  oe = 1'b0;
      TS_FRAME:  oe = framing;
      TS_ALWAYS: oe = 1'b1;
      default:   oe = 1'b0;
    endcase
    return oe;
  endfunction

endpackage

// File: rtl/ioblock_pad.sv
// Pad cell: registered drive/oe flops with tristate onto PIN, plus IN capture flop.
// Latency: drv_d/oe_d appear on PIN one IOCLK edge later; IN lags PIN by one edge.
// Backpressure: none, the pad follows its next-value inputs every cycle.
// Ports: IOCLK clock, RSTN async active-low reset, drv_d/oe_d next drive/enable,
//        PIN bidirectional pad, IN registered copy of the pad level.
module ioblock_pad #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic IOCLK,
  input  logic RSTN,
  input  logic drv_d,
  input  logic oe_d,
  inout  wire  PIN,
  output logic IN
);

  logic drv_q;
  logic oe_q;

  // oe_q clears asynchronously, so the pad releases the instant RSTN falls.
  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      drv_q <= IDLE_LEVEL;
      oe_q  <= 1'b0;
      IN    <= 1'b0;
    end else begin
      drv_q <= drv_d;
      oe_q  <= oe_d;
      IN    <= PIN;
    end
  end

  assign PIN = oe_q ? drv_q : 1'bz;

endmodule

// File: rtl/ioblock_tx.sv
// Transmit IO block: serializes DATA words onto PIN as start/data(LSB first)/stop frames.
// Latency: PIN shows the start bit right after the accepting edge; frame is WIDTH+2 cycles
//          (WIDTH+3 with IOBLOCK_TX_PARITY_EN). Backpressure: READY low in START/DATA(/PARITY),
//          high in IDLE and STOP so back-to-back words leave no idle gap.
// Ports: IOCLK, RSTN (async active-low), DATA/VALID/READY word handshake, TSMUX drive policy,
//        PIN pad, IN loopback capture, BUSY frame in progress.
// Optional build macro: IOBLOCK_TX_PARITY_EN inserts an even-parity bit before STOP.
module ioblock_tx
  import ioblock_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             IOCLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  input  logic [1:0]       TSMUX,
  inout  wire              PIN,
  output logic             IN,
  output logic             BUSY
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             accept;
  logic             drv_d;
  logic             oe_d;
`ifdef IOBLOCK_TX_PARITY_EN
  logic             par_q;
  logic             par_nxt;
`endif

  assign READY  = (state == ST_IDLE) || (state == ST_STOP);
  assign BUSY   = (state != ST_IDLE);
  assign accept = VALID && READY;

  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef IOBLOCK_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
`ifdef IOBLOCK_TX_PARITY_EN
      par_q <= par_nxt;
`endif
    end
  end

  // Next state. The shift register shifts on every DATA edge, so the bit
  // about to go out is always shreg_nxt[0] when the next state is DATA
  // (START->DATA holds, so bit 0 leads).
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
`ifdef IOBLOCK_TX_PARITY_EN
    par_nxt   = par_q;
`endif
    case (state)
      ST_IDLE, ST_STOP: begin
        if (accept) begin
          state_nxt = ST_START;
          shreg_nxt = DATA;
`ifdef IOBLOCK_TX_PARITY_EN
          par_nxt   = ^DATA;
`endif
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt = ST_DATA;
        cnt_nxt   = '0;
      end
      ST_DATA: begin
        shreg_nxt = shreg >> 1;
        if (cnt == LAST) begin
`ifdef IOBLOCK_TX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef IOBLOCK_TX_PARITY_EN
      ST_PARITY: state_nxt = ST_STOP;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Drive level and enable are decided from the next state so the registered
  // pad lines up with the state register.
  always_comb begin
    drv_d = IDLE_LEVEL;
    case (state_nxt)
      ST_START:  drv_d = START_BIT;
      ST_DATA:   drv_d = shreg_nxt[0];
`ifdef IOBLOCK_TX_PARITY_EN
      ST_PARITY: drv_d = par_nxt;
`endif
      ST_STOP:   drv_d = STOP_BIT;
      default:   drv_d = IDLE_LEVEL;
    endcase
    oe_d = ts_oe(TSMUX, state_nxt != ST_IDLE);
  end

  ioblock_pad #(
    .IDLE_LEVEL(IDLE_LEVEL)
  ) u_pad (
    .IOCLK (IOCLK),
    .RSTN  (RSTN),
    .drv_d (drv_d),
    .oe_d  (oe_d),
    .PIN   (PIN),
    .IN    (IN)
  );

endmodule

// File: tb/tb_ioblock_tx.sv
// Directed bench for ioblock_tx (WIDTH=8, IDLE_LEVEL=1); the pad carries a pullup,
// so a released pin reads 1 and the pad enable is observed alongside the level.
module tb_ioblock_tx;

`ifdef IOBLOCK_TX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic       ioclk;
  logic       rstn;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [1:0] tsmux;
  wire        pin;
  logic       in_s;
  logic       busy;

  int   total;
  int   bad;
  logic lvl_prev;

  pullup (pin);

  ioblock_tx #(
    .WIDTH      (8),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .IOCLK (ioclk),
    .RSTN  (rstn),
    .DATA  (data),
    .VALID (valid),
    .READY (ready),
    .TSMUX (tsmux),
    .PIN   (pin),
    .IN    (in_s),
    .BUSY  (busy)
  );

  initial begin
    ioclk = 1'b0;
    forever #5 ioclk = ~ioclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drv=0 means the pad must be released (reads the pullup level).
  task automatic chk_pad(input string tag, input bit drv, input logic lvl);
    chk({tag, ".oe"},  {31'd0, dut.u_pad.oe_q}, {31'd0, drv});
    chk({tag, ".pin"}, {31'd0, pin}, {31'd0, (drv ? lvl : 1'b1)});
  endtask

  // Expected pad level for bit i of a frame carrying w.
  function automatic logic frame_bit(input logic [7:0] w, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return w[i-1];
`ifdef IOBLOCK_TX_PARITY_EN
    if (i == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge ioclk);
    #1;
  endtask

  // Called #1 after the accepting edge; returns #1 after the edge ending the frame.
  task automatic frame_chk(input string tag, input logic [7:0] w, input bit drv);
    for (int i = 0; i < FLEN; i++) begin
      logic b;
      b = frame_bit(w, i);
      chk_pad($sformatf("%s.b%0d", tag, i), drv, b);
      chk($sformatf("%s.busy%0d", tag, i), {31'd0, busy}, 32'd1);
      chk($sformatf("%s.ready%0d", tag, i), {31'd0, ready}, {31'd0, (i == FLEN - 1)});
      chk($sformatf("%s.in%0d", tag, i), {31'd0, in_s}, {31'd0, lvl_prev});
      lvl_prev = drv ? b : 1'b1;
      tick();
    end
  endtask

  initial begin
    logic [9:0] a5_hand;
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    tsmux = 2'b01;
    a5_hand = 10'b1101001010;

    // Reset state.
    tick();
    chk_pad("rst", 1'b0, 1'b1);
    chk("rst.ready", {31'd0, ready}, 32'd1);
    chk("rst.busy",  {31'd0, busy},  32'd0);
    chk("rst.in",    {31'd0, in_s},  32'd0);

    // Single word A5, drive only while framing; DATA changes after accept.
    @(negedge ioclk);
    rstn  = 1'b1;
    data  = 8'hA5;
    valid = 1'b1;
    lvl_prev = 1'b1;
    tick();
    valid = 1'b0;
    data  = 8'h5A;
`ifndef IOBLOCK_TX_PARITY_EN
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a5hand.b%0d", i), {31'd0, pin}, {31'd0, a5_hand[i]});
      chk($sformatf("a5hand.busy%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("a5hand.ready%0d", i), {31'd0, ready}, {31'd0, (i == 9)});
      tick();
    end
`else
    frame_chk("a5", 8'hA5, 1'b1);
`endif
    chk_pad("a5.after", 1'b0, 1'b1);
    chk("a5.after.busy",  {31'd0, busy},  32'd0);
    chk("a5.after.ready", {31'd0, ready}, 32'd1);
    chk("a5.after.in",    {31'd0, in_s},  32'd1);

    // Back-to-back 00 then FF with VALID held; second accept lands in STOP.
    tick();
    data  = 8'h00;
    valid = 1'b1;
    lvl_prev = 1'b1;
    tick();
    data = 8'hFF;
    frame_chk("b2b0", 8'h00, 1'b1);
    valid = 1'b0;
    frame_chk("b2b1", 8'hFF, 1'b1);
    chk_pad("b2b.after", 1'b0, 1'b1);
    chk("b2b.after.busy", {31'd0, busy}, 32'd0);

    // Never drive: timing unchanged, pad stays released, IN sees the pullup.
    tsmux = 2'b00;
    data  = 8'h3C;
    valid = 1'b1;
    lvl_prev = 1'b1;
    tick();
    valid = 1'b0;
    frame_chk("nodrv", 8'h3C, 1'b0);
    chk("nodrv.after.busy", {31'd0, busy}, 32'd0);

    // Always drive while idle, then release one edge after switching to 00.
    tsmux = 2'b10;
    chk_pad("ts10.pre", 1'b0, 1'b1);
    tick();
    chk_pad("ts10.e1", 1'b1, 1'b1);
    tsmux = 2'b11;
    tick();
    chk_pad("ts11.e1", 1'b1, 1'b1);
    tick();
    chk_pad("ts11.e2", 1'b1, 1'b1);
    tsmux = 2'b00;
    chk_pad("ts00.pre", 1'b1, 1'b1);
    tick();
    chk_pad("ts00.e1", 1'b0, 1'b1);

    // Reset during data bit 3 of A5.
    tsmux = 2'b01;
    data  = 8'hA5;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (4) tick();
    chk_pad("mid.bit3", 1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    chk_pad("mid.rst", 1'b0, 1'b1);
    chk("mid.rst.busy",  {31'd0, busy},  32'd0);
    chk("mid.rst.ready", {31'd0, ready}, 32'd1);
    chk("mid.rst.in",    {31'd0, in_s},  32'd0);
    tick();
    chk_pad("mid.hold", 1'b0, 1'b1);
    @(negedge ioclk);
    rstn  = 1'b1;
    data  = 8'h01;
    valid = 1'b1;
    lvl_prev = 1'b1;
    tick();
    valid = 1'b0;
    frame_chk("post", 8'h01, 1'b1);
    chk_pad("post.after", 1'b0, 1'b1);
    chk("post.after.busy", {31'd0, busy}, 32'd0);

`ifdef IOBLOCK_TX_PARITY_EN
    // 07 has three ones, so the parity bit is 1.
    data  = 8'h07;
    valid = 1'b1;
    lvl_prev = 1'b1;
    tick();
    valid = 1'b0;
    frame_chk("par", 8'h07, 1'b1);
    chk("par.after.busy", {31'd0, busy}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
